// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester and unified-memory signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
               mem_cs, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester and memory side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
               mem_cs, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-latency arbiter sharing one single-ported memory between fetch and data
module mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 2,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [SW-1:0] MAX_S     = SW'(MAX_DM_STREAK);
    localparam logic [WW-1:0] WAIT_INIT = WW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              grant_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_q     <= '0;
            streak_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            streak_q   <= streak_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Data wins unless fetch is waiting and data has already used up its streak.
    assign grant_dm = bus.dm_req && (!bus.if_req || (streak_q < MAX_S));

    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        streak_d   = streak_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    owner_dm_d = 1'b1;
                    addr_d     = bus.dm_addr;
                    wdata_d    = bus.dm_wdata;
                    we_d       = bus.dm_we;
                    wait_d     = WAIT_INIT;
                    state_d    = ACCESS;
                    if (bus.if_req && (streak_q != MAX_S)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (bus.if_req) begin
                    owner_dm_d = 1'b0;
                    addr_d     = bus.if_addr;
                    we_d       = 1'b0;
                    wait_d     = WAIT_INIT;
                    state_d    = ACCESS;
                    streak_d   = '0;
                end
            end
            ACCESS: begin
                if (wait_q == '0) begin
                    if (!we_q) begin
                        if (owner_dm_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                    state_d = DONE;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_cs    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ready  = (state_q == DONE) && !owner_dm_q;
    assign bus.dm_ready  = (state_q == DONE) && owner_dm_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
